// File: rtl/bcd_scan_counter_if.sv
// +-----------------------------------------------------------------------+
// | bcd_scan_counter_if : control/display bundle for bcd_scan_counter      |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

interface bcd_scan_counter_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  up_dn;
  logic                  clr;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  tc;
  logic [6:0]            seg;
  logic [DIGITS-1:0]     an;

  modport master (
    output en, up_dn, clr, load, load_val,
    input  bcd_out, tc, seg, an
  );

  modport slave (
    input  en, up_dn, clr, load, load_val,
    output bcd_out, tc, seg, an
  );
endinterface

`default_nettype wire

// File: rtl/bcd_scan_counter.sv
// +-----------------------------------------------------------------------+
// | bcd_scan_counter : N-digit BCD up/down counter with 7-segment scanner  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module bcd_scan_counter #(
  parameter int DIGITS   = 4,
  parameter int CNT_DIV  = 2500000,
  parameter int SCAN_DIV = 5000,
  parameter int BLANK_LZ = 0
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  bcd_scan_counter_if.slave   bus
);

  localparam int c_CNT_W  = $clog2(CNT_DIV);
  localparam int c_SCAN_W = $clog2(SCAN_DIV);
  localparam int c_IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [c_CNT_W-1:0]  c_CNT_MAX  = c_CNT_W'(CNT_DIV - 1);
  localparam logic [c_SCAN_W-1:0] c_SCAN_MAX = c_SCAN_W'(SCAN_DIV - 1);
  localparam logic [c_IDX_W-1:0]  c_IDX_LAST = c_IDX_W'(DIGITS - 1);

  logic [c_CNT_W-1:0]    r_tick_cnt;
  logic [c_SCAN_W-1:0]   r_scan_cnt;
  logic [c_IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0]   r_bcd;
  logic                  r_tc;
  logic [DIGITS-1:0]     r_an;
  logic [6:0]            r_seg;

  logic                  w_tick;
  logic                  w_scan_wrap;
  logic [4*DIGITS-1:0]   w_inc;
  logic [4*DIGITS-1:0]   w_dec;
  logic [4*DIGITS-1:0]   w_load;
  logic                  w_carry;
  logic                  w_borrow;
  logic [c_IDX_W-1:0]    w_idx_nxt;
  logic [DIGITS-1:0]     w_an_nxt;
  logic [3:0]            w_digit;
  logic                  w_zero_above;
  logic                  w_blank;
  logic [6:0]            w_seg_nxt;

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 7'b0000001;
      4'd1:    f_seg = 7'b1001111;
      4'd2:    f_seg = 7'b0010010;
      4'd3:    f_seg = 7'b0000110;
      4'd4:    f_seg = 7'b1001100;
      4'd5:    f_seg = 7'b0100100;
      4'd6:    f_seg = 7'b0100000;
      4'd7:    f_seg = 7'b0001111;
      4'd8:    f_seg = 7'b0000000;
      4'd9:    f_seg = 7'b0000100;
      default: f_seg = 7'b1111110;
    endcase
  endfunction

  assign w_tick      = (r_tick_cnt == c_CNT_MAX);
  assign w_scan_wrap = (r_scan_cnt == c_SCAN_MAX);

  // Ripple carry/borrow out of the top digit doubles as the wrap flag.
  always_comb begin
    w_inc    = r_bcd;
    w_dec    = r_bcd;
    w_load   = '0;
    w_carry  = 1'b1;
    w_borrow = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (w_carry) begin
        if (r_bcd[4*k +: 4] == 4'd9) begin
          w_inc[4*k +: 4] = 4'd0;
        end else begin
          w_inc[4*k +: 4] = r_bcd[4*k +: 4] + 4'd1;
          w_carry         = 1'b0;
        end
      end
      if (w_borrow) begin
        if (r_bcd[4*k +: 4] == 4'd0) begin
          w_dec[4*k +: 4] = 4'd9;
        end else begin
          w_dec[4*k +: 4] = r_bcd[4*k +: 4] - 4'd1;
          w_borrow        = 1'b0;
        end
      end
      w_load[4*k +: 4] = (bus.load_val[4*k +: 4] > 4'd9) ? 4'd0 : bus.load_val[4*k +: 4];
    end
  end

  // Walk from the top digit down so the leading-zero run is known at each k.
  always_comb begin
    if (!w_scan_wrap) begin
      w_idx_nxt = r_idx;
    end else if (r_idx == c_IDX_LAST) begin
      w_idx_nxt = '0;
    end else begin
      w_idx_nxt = r_idx + 1'b1;
    end
    w_an_nxt     = '0;
    w_digit      = 4'd0;
    w_zero_above = 1'b1;
    w_blank      = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_zero_above = w_zero_above & (r_bcd[4*k +: 4] == 4'd0);
      if (w_idx_nxt == c_IDX_W'(k)) begin
        w_an_nxt[k] = 1'b1;
        w_digit     = r_bcd[4*k +: 4];
        w_blank     = (BLANK_LZ != 0) && (k != 0) && w_zero_above;
      end
    end
    w_seg_nxt = w_blank ? 7'b1111111 : f_seg(w_digit);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if (bus.clr || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bcd <= '0;
      r_tc  <= 1'b0;
    end else if (bus.clr) begin
      r_bcd <= '0;
      r_tc  <= 1'b0;
    end else if (bus.load) begin
      r_bcd <= w_load;
      r_tc  <= 1'b0;
    end else if (w_tick && bus.en) begin
      r_bcd <= bus.up_dn ? w_inc : w_dec;
      r_tc  <= bus.up_dn ? w_carry : w_borrow;
    end else begin
      r_tc  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
      r_an       <= DIGITS'(1);
      r_seg      <= 7'b0000001;
    end else begin
      r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + 1'b1;
      r_idx      <= w_idx_nxt;
      r_an       <= w_an_nxt;
      r_seg      <= w_seg_nxt;
    end
  end

  assign bus.bcd_out = r_bcd;
  assign bus.tc      = r_tc;
  assign bus.an      = r_an;
  assign bus.seg     = r_seg;

endmodule

`default_nettype wire

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench for bcd_scan_counter: integer reference model, two DUTs
// (without and with leading-zero blanking) driven by the same stimulus.
`default_nettype none

module tb_bcd_scan_counter;
  localparam int DIGITS   = 4;
  localparam int CNT_DIV  = 10;
  localparam int SCAN_DIV = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_scan_counter_if #(.DIGITS(DIGITS)) bus0 ();
  bcd_scan_counter_if #(.DIGITS(DIGITS)) bus1 ();

  bcd_scan_counter #(.DIGITS(DIGITS), .CNT_DIV(CNT_DIV), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(0))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  bcd_scan_counter #(.DIGITS(DIGITS), .CNT_DIV(CNT_DIV), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct {
    logic [15:0] bcd;
    logic        tc;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [6:0]  segb;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  logic        s_rst_n = 1'b0, s_en = 1'b0, s_up = 1'b1, s_clr = 1'b0, s_load = 1'b0;
  logic [15:0] s_lval  = 16'h0;

  int   m_val = 0, m_tick = 0, m_scan = 0, m_idx = 0;
  logic m_tc = 1'b0;
  logic [6:0] m_seg = 7'b0000001, m_segb = 7'b0000001;

  function automatic int p10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111110;
    endcase
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] b = '0;
    for (int k = 0; k < DIGITS; k++) b[4*k +: 4] = 4'((v / p10(k)) % 10);
    return b;
  endfunction

  function automatic int load_int(input logic [15:0] lv);
    int r = 0;
    int nib;
    for (int k = 0; k < DIGITS; k++) begin
      nib = int'(lv[4*k +: 4]);
      if (nib <= 9) r += nib * p10(k);
    end
    return r;
  endfunction

  task automatic model_step();
    bit   tick_now;
    int   dig;
    int   full;
    exp_t e;
    full = p10(DIGITS);
    if (!s_rst_n) begin
      m_val = 0; m_tc = 1'b0; m_tick = 0; m_scan = 0; m_idx = 0;
      m_seg = enc(0); m_segb = enc(0);
    end else begin
      tick_now = (m_tick == CNT_DIV - 1);
      if (m_scan == SCAN_DIV - 1) begin
        m_scan = 0;
        m_idx  = (m_idx + 1) % DIGITS;
      end else begin
        m_scan++;
      end
      // Display reflects the count as it stood before this edge.
      dig    = (m_val / p10(m_idx)) % 10;
      m_seg  = enc(dig);
      m_segb = (m_idx > 0 && m_val < p10(m_idx)) ? 7'b1111111 : enc(dig);
      if (s_clr) begin
        m_val = 0; m_tc = 1'b0;
      end else if (s_load) begin
        m_val = load_int(s_lval); m_tc = 1'b0;
      end else if (tick_now && s_en) begin
        if (s_up) begin
          m_tc  = (m_val == full - 1);
          m_val = (m_val + 1) % full;
        end else begin
          m_tc  = (m_val == 0);
          m_val = (m_val + full - 1) % full;
        end
      end else begin
        m_tc = 1'b0;
      end
      if (s_clr || tick_now) m_tick = 0;
      else                   m_tick++;
    end
    e.bcd  = to_bcd(m_val);
    e.tc   = m_tc;
    e.an   = 4'(1 << m_idx);
    e.seg  = m_seg;
    e.segb = m_segb;
    q.push_back(e);
  endtask

  task automatic drive_cycle();
    @(negedge clk);
    rst_n         = s_rst_n;
    bus0.en       = s_en;   bus1.en       = s_en;
    bus0.up_dn    = s_up;   bus1.up_dn    = s_up;
    bus0.clr      = s_clr;  bus1.clr      = s_clr;
    bus0.load     = s_load; bus1.load     = s_load;
    bus0.load_val = s_lval; bus1.load_val = s_lval;
    model_step();
  endtask

  task automatic run(input int n);
    repeat (n) drive_cycle();
  endtask

  task automatic set_in(input logic rn, input logic en, input logic up,
                        input logic clr, input logic ld, input logic [15:0] lv);
    s_rst_n = rn; s_en = en; s_up = up; s_clr = clr; s_load = ld; s_lval = lv;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("bcd_out",      32'(bus0.bcd_out), 32'(e.bcd));
        chk("tc",           32'(bus0.tc),      32'(e.tc));
        chk("an",           32'(bus0.an),      32'(e.an));
        chk("seg",          32'(bus0.seg),     32'(e.seg));
        chk("bcd_out_blz",  32'(bus1.bcd_out), 32'(e.bcd));
        chk("tc_blz",       32'(bus1.tc),      32'(e.tc));
        chk("an_blz",       32'(bus1.an),      32'(e.an));
        chk("seg_blz",      32'(bus1.seg),     32'(e.segb));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bus0.en = 1'b0; bus0.up_dn = 1'b1; bus0.clr = 1'b0; bus0.load = 1'b0; bus0.load_val = '0;
    bus1.en = 1'b0; bus1.up_dn = 1'b1; bus1.clr = 1'b0; bus1.load = 1'b0; bus1.load_val = '0;

    set_in(0, 1, 1, 0, 0, 16'h0);    run(3);
    set_in(1, 1, 1, 0, 0, 16'h0);    run(110);
    // Up wrap through 9999.
    set_in(1, 0, 1, 0, 1, 16'h9998); run(1);
    set_in(1, 1, 1, 0, 0, 16'h0);    run(25);
    // Down wrap and multi-digit borrow.
    set_in(1, 0, 0, 0, 1, 16'h0001); run(1);
    set_in(1, 1, 0, 0, 0, 16'h0);    run(25);
    set_in(1, 0, 0, 0, 1, 16'h1000); run(1);
    set_in(1, 1, 0, 0, 0, 16'h0);    run(12);
    // Invalid digits, clr over load, load across a tick, clr mid-period.
    set_in(1, 0, 1, 0, 1, 16'h0A5F); run(1);
    set_in(1, 0, 1, 0, 0, 16'h0);    run(3);
    set_in(1, 1, 1, 1, 1, 16'h4321); run(1);
    set_in(1, 1, 1, 0, 1, 16'h1234); run(12);
    set_in(1, 1, 1, 0, 0, 16'h0);    run(4);
    set_in(1, 1, 1, 1, 0, 16'h0);    run(1);
    set_in(1, 1, 1, 0, 0, 16'h0);    run(12);
    // Static scan patterns, including leading-zero cases.
    set_in(1, 0, 1, 0, 1, 16'h1234); run(1);
    set_in(1, 0, 1, 0, 0, 16'h0);    run(20);
    set_in(1, 0, 1, 0, 1, 16'h0007); run(1);
    set_in(1, 0, 1, 0, 0, 16'h0);    run(20);
    set_in(1, 0, 1, 0, 1, 16'h0000); run(1);
    set_in(1, 0, 1, 0, 0, 16'h0);    run(20);
    // Reset asserted while the third digit is selected.
    set_in(1, 0, 1, 0, 1, 16'h0507); run(1);
    set_in(1, 0, 1, 0, 0, 16'h0);
    for (int i = 0; i < 16 && m_idx != 2; i++) run(1);
    set_in(0, 1, 1, 0, 0, 16'h0);    run(1);
    set_in(1, 1, 1, 0, 0, 16'h0);    run(5);

    for (int i = 0; i < 3000; i++) begin
      s_rst_n = ($urandom_range(0, 199) != 0);
      s_clr   = ($urandom_range(0, 59) == 0);
      s_load  = ($urandom_range(0, 29) == 0);
      case ($urandom_range(0, 4))
        0:       s_lval = 16'h9999;
        1:       s_lval = 16'h0000;
        2:       s_lval = 16'h9990;
        3:       s_lval = 16'h0010;
        default: s_lval = 16'($urandom);
      endcase
      s_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) s_up = ~s_up;
      run(1);
    end

    set_in(1, 0, 1, 0, 0, 16'h0);
    run(2);
    @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
